// File: rtl/program_loader.sv
// program_loader
//   Boot-time loader that sits in front of the instruction memory. It receives a
//   framed byte stream (HEADER, length N, 4*N payload bytes, XOR checksum), packs
//   the payload little-endian into 32-bit words and writes them to instruction
//   memory starting at BASE_ADDR. The processor is held in reset until a whole
//   frame has been written and its checksum matches.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous reset, active low (0 = reset)
//   rx_valid    rx_data holds a byte this cycle
//   rx_data     incoming byte
//   rx_ready    loader accepts a byte; a transfer happens on rx_valid & rx_ready
//   imem_we     one-cycle instruction-memory write strobe
//   imem_addr   word-aligned byte address of the write (held between writes)
//   imem_wdata  word being written (held between writes)
//   core_reset  active-high reset to the processor
//   done        frame loaded and checksum correct
//   error       frame rejected (bad length or bad checksum)
//   word_count  words written in the current frame
module program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 64,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [7:0]  word_count
);

  typedef enum logic [2:0] {
    StIdle, StLen, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  localparam logic [7:0] MaxWordsB = 8'(MAX_WORDS);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  wc_q, wc_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  // Holds the first three payload bytes of a word; the fourth byte is taken
  // straight from rx_data when the word is completed.
  logic [23:0] shift_q, shift_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        accept;

  assign accept     = rx_valid & rx_ready;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = wc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      len_q     <= 8'd0;
      csum_q    <= 8'd0;
      wc_q      <= 8'd0;
      byteIdx_q <= 2'd0;
      shift_q   <= 24'd0;
      addr_q    <= BASE_ADDR;
      wdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      csum_q    <= csum_d;
      wc_q      <= wc_d;
      byteIdx_q <= byteIdx_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    wc_d       = wc_q;
    byteIdx_d  = byteIdx_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rx_ready   = 1'b1;
    imem_we    = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_reset = 1'b1;

    case (state_q)
      StIdle: begin
        if (accept && rx_data == HEADER) begin
          state_d   = StLen;
          csum_d    = 8'd0;
          wc_d      = 8'd0;
          byteIdx_d = 2'd0;
        end
      end

      StLen: begin
        if (accept) begin
          len_d   = rx_data;
          state_d = (rx_data != 8'd0 && rx_data <= MaxWordsB) ? StData : StErr;
        end
      end

      StData: begin
        if (accept) begin
          csum_d    = csum_q ^ rx_data;
          shift_d   = {rx_data, shift_q[23:8]};
          byteIdx_d = byteIdx_q + 2'd1;
          // Fourth byte: latch address and word now so they are already
          // presented on the memory port during the write cycle.
          if (byteIdx_q == 2'd3) begin
            addr_d  = BASE_ADDR + {22'd0, wc_q, 2'b00};
            wdata_d = {rx_data, shift_q};
            state_d = StWrite;
          end
        end
      end

      StWrite: begin
        rx_ready = 1'b0;
        imem_we  = 1'b1;
        wc_d     = wc_q + 8'd1;
        state_d  = (wc_q + 8'd1 == len_q) ? StCsum : StData;
      end

      StCsum: begin
        if (accept) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end

      StDone: begin
        rx_ready   = 1'b0;
        done       = 1'b1;
        core_reset = 1'b0;
      end

      StErr: begin
        error = 1'b1;
        // Only a fresh header restarts loading; everything else is dropped.
        if (accept && rx_data == HEADER) begin
          state_d   = StLen;
          csum_d    = 8'd0;
          wc_d      = 8'd0;
          byteIdx_d = 2'd0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
//   Self-checking bench for program_loader: a table of complete frames with
//   hand-derived results, hand-written multi-cycle sequences (multi-word frame,
//   recovery after a bad checksum, valid gaps, reset mid-frame) and randomized
//   frames checked against a frame-level reference model.
module tb_program_loader;

  localparam int unsigned MAXW = 64;
  localparam logic [7:0]  HDR  = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [7:0]  word_count;

  int total = 0;
  int bad   = 0;

  program_loader #(
    .BASE_ADDR (32'h0),
    .MAX_WORDS (MAXW),
    .HEADER    (HDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Record every memory write and every stall cycle (rx_ready low while the
  // frame is still loading). Sampled on the falling edge, away from the
  // active edge.
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  int          notReadyCnt = 0;

  always @(negedge clk) begin
    if (reset && imem_we) begin
      wrAddrQ.push_back(imem_addr);
      wrDataQ.push_back(imem_wdata);
    end
    if (reset && !rx_ready && !done) notReadyCnt++;
  end

  // Hang guard: a stuck run still reports a failure before stopping.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one value and keep the counters.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Hold reset for two cycles and release it on a falling edge.
  task automatic doReset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Transfer one byte: optional idle gap, then hold rx_valid until the loader
  // is ready and the byte is taken on a rising edge. A bounded wait counts as
  // a failed comparison if the loader never becomes ready.
  task automatic sendByte(input logic [7:0] b, input int gap);
    int waitCnt;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waitCnt  = 0;
    while (!rx_ready && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!rx_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake: rx_ready stuck at %0b for byte %0h", rx_ready, b);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  // Send the whole byte stream with random idle gaps in [minGap, maxGap].
  logic [7:0] stream[$];

  task automatic applyStimulus(input int minGap, input int maxGap);
    for (int k = 0; k < stream.size(); k++)
      sendByte(stream[k], int'($urandom_range(maxGap, minGap)));
  endtask

  // Frame-level reference: find the header, read the length, cut the payload
  // into little-endian words and XOR it, then judge the checksum byte.
  logic [31:0] expWords[$];
  logic        expDone, expErr;
  logic [7:0]  expWc;

  function automatic void refModel(input logic [7:0] s[$]);
    int          p;
    int          n;
    logic [7:0]  x;
    logic [31:0] word;
    expWords.delete();
    expDone = 1'b0;
    expErr  = 1'b0;
    expWc   = 8'd0;
    p = 0;
    while (p < s.size() && s[p] != HDR) p++;
    if (p + 1 >= s.size()) return;
    n = int'(s[p+1]);
    if (n < 1 || n > int'(MAXW)) begin
      expErr = 1'b1;
      return;
    end
    x = 8'd0;
    for (int w = 0; w < n; w++) begin
      word = 32'd0;
      for (int b = 0; b < 4; b++) begin
        word = word | (32'(s[p + 2 + 4*w + b]) << (8*b));
        x    = x ^ s[p + 2 + 4*w + b];
      end
      expWords.push_back(word);
    end
    expWc = 8'(n);
    if (s[p + 2 + 4*n] == x) expDone = 1'b1;
    else                     expErr  = 1'b1;
  endfunction

  // Table of complete frames, each run from reset, with hand-derived results.
  typedef struct {
    logic [7:0]  bytes [16];
    int          nBytes;
    int          expWe;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic        expDone;
    logic        expErr;
    logic [7:0]  expWc;
  } vec_t;

  localparam int NVEC = 7;
  vec_t vecs[NVEC];

  task automatic addVec(input int i, input int we, input logic [31:0] a, input logic [31:0] d,
                        input logic dn, input logic er, input logic [7:0] wc);
    vecs[i].nBytes = stream.size();
    for (int k = 0; k < 16; k++) vecs[i].bytes[k] = (k < stream.size()) ? stream[k] : 8'h00;
    vecs[i].expWe   = we;
    vecs[i].expAddr = a;
    vecs[i].expData = d;
    vecs[i].expDone = dn;
    vecs[i].expErr  = er;
    vecs[i].expWc   = wc;
  endtask

  // Final-state checks shared by the table and the hand sequences.
  task automatic checkFrame(input string tag, input int weStart, input int expWe,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic dn, input logic er, input logic [7:0] wc);
    checkOutput({tag, " writes"},     32'(wrAddrQ.size() - weStart), 32'(expWe));
    checkOutput({tag, " imem_addr"},  imem_addr, a);
    checkOutput({tag, " imem_wdata"}, imem_wdata, d);
    checkOutput({tag, " done"},       32'(done), 32'(dn));
    checkOutput({tag, " error"},      32'(error), 32'(er));
    checkOutput({tag, " core_reset"}, 32'(core_reset), 32'(!dn));
    checkOutput({tag, " word_count"}, 32'(word_count), 32'(wc));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " rx_ready"},   32'(rx_ready), 32'd1);
    checkOutput({tag, " imem_we"},    32'(imem_we), 32'd0);
    checkOutput({tag, " imem_addr"},  imem_addr, 32'h0);
    checkOutput({tag, " imem_wdata"}, imem_wdata, 32'h0);
    checkOutput({tag, " core_reset"}, 32'(core_reset), 32'd1);
    checkOutput({tag, " done"},       32'(done), 32'd0);
    checkOutput({tag, " error"},      32'(error), 32'd0);
    checkOutput({tag, " word_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    int weStart;
    int nrStart;
    int n;
    int nw;

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Outputs while reset is held.
    #1;
    checkResetValues("reset");

    // Build the frame table.
    stream = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    addVec(0, 1, 32'h0, 32'h12345678, 1'b1, 1'b0, 8'd1);
    stream = '{8'hA5, 8'h00};
    addVec(1, 0, 32'h0, 32'h0, 1'b0, 1'b1, 8'd0);
    stream = '{8'hA5, 8'h41};
    addVec(2, 0, 32'h0, 32'h0, 1'b0, 1'b1, 8'd0);
    stream = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    addVec(3, 1, 32'h0, 32'h12345678, 1'b1, 1'b0, 8'd1);
    stream = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    addVec(4, 1, 32'h0, 32'h12345678, 1'b0, 1'b1, 8'd1);
    stream = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
    addVec(5, 2, 32'h4, 32'h2, 1'b1, 1'b0, 8'd2);
    stream = '{8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    addVec(6, 1, 32'h0, 32'hA5A5A5A5, 1'b1, 1'b0, 8'd1);

    for (int i = 0; i < NVEC; i++) begin
      doReset();
      weStart = wrAddrQ.size();
      stream.delete();
      for (int k = 0; k < vecs[i].nBytes; k++) stream.push_back(vecs[i].bytes[k]);
      applyStimulus(0, 0);
      repeat (3) @(negedge clk);
      checkFrame($sformatf("vec%0d", i), weStart, vecs[i].expWe, vecs[i].expAddr,
                 vecs[i].expData, vecs[i].expDone, vecs[i].expErr, vecs[i].expWc);
    end

    // Three-word frame: writes at 0,4,8 and exactly three single stall cycles.
    doReset();
    weStart = wrAddrQ.size();
    nrStart = notReadyCnt;
    stream = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkFrame("n3", weStart, 3, 32'h8, 32'h3, 1'b1, 1'b0, 8'd3);
    checkOutput("n3 stall cycles", 32'(notReadyCnt - nrStart), 32'd3);
    for (int w = 0; w < 3; w++) begin
      if (weStart + w < wrAddrQ.size()) begin
        checkOutput($sformatf("n3 addr%0d", w), wrAddrQ[weStart + w], 32'(4 * w));
        checkOutput($sformatf("n3 data%0d", w), wrDataQ[weStart + w], 32'(w + 1));
      end
    end

    // Bad checksum, then a good frame without an intervening reset.
    doReset();
    weStart = wrAddrQ.size();
    stream = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
               8'h03, 8'h00, 8'h00, 8'h00, 8'h55};
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkFrame("badcs", weStart, 3, 32'h8, 32'h3, 1'b0, 1'b1, 8'd3);
    stream = '{8'h13, 8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkFrame("recover", weStart, 4, 32'h0, 32'h12345678, 1'b1, 1'b0, 8'd1);

    // Idle gaps between every byte, including inside the word.
    doReset();
    weStart = wrAddrQ.size();
    stream = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    applyStimulus(2, 4);
    repeat (3) @(negedge clk);
    checkFrame("gaps", weStart, 1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0, 8'd1);

    // Reset in the middle of a word, then a fresh frame.
    doReset();
    stream = '{8'hA5, 8'h01, 8'h78, 8'h56};
    applyStimulus(0, 0);
    reset = 1'b0;
    #2;
    checkResetValues("midreset");
    @(negedge clk);
    reset = 1'b1;
    weStart = wrAddrQ.size();
    stream = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    applyStimulus(0, 0);
    repeat (3) @(negedge clk);
    checkFrame("afterreset", weStart, 1, 32'h0, 32'h12345678, 1'b1, 1'b0, 8'd1);

    // Randomized frames against the reference model.
    for (int it = 0; it < 30; it++) begin
      doReset();
      weStart = wrAddrQ.size();
      stream.delete();
      repeat ($urandom_range(3, 0)) begin
        logic [7:0] j;
        j = 8'($urandom);
        if (j == HDR) j = 8'h5A;
        stream.push_back(j);
      end
      stream.push_back(HDR);
      if ($urandom_range(5, 0) == 0) begin
        n = ($urandom_range(1, 0) == 0) ? 0 : int'($urandom_range(255, MAXW + 1));
        stream.push_back(8'(n));
      end else begin
        logic [7:0] x;
        n = int'($urandom_range(6, 1));
        stream.push_back(8'(n));
        x = 8'd0;
        for (int k = 0; k < 4 * n; k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          x = x ^ b;
          stream.push_back(b);
        end
        if ($urandom_range(3, 0) == 0) x = x ^ 8'(int'($urandom_range(255, 1)));
        stream.push_back(x);
      end
      refModel(stream);
      applyStimulus(0, 2);
      repeat (3) @(negedge clk);
      nw = wrAddrQ.size() - weStart;
      checkOutput($sformatf("rnd%0d writes", it), 32'(nw), 32'(expWords.size()));
      for (int w = 0; w < expWords.size() && w < nw; w++) begin
        checkOutput($sformatf("rnd%0d addr%0d", it, w), wrAddrQ[weStart + w], 32'(4 * w));
        checkOutput($sformatf("rnd%0d data%0d", it, w), wrDataQ[weStart + w], expWords[w]);
      end
      checkOutput($sformatf("rnd%0d done", it),       32'(done), 32'(expDone));
      checkOutput($sformatf("rnd%0d error", it),      32'(error), 32'(expErr));
      checkOutput($sformatf("rnd%0d core_reset", it), 32'(core_reset), 32'(!expDone));
      checkOutput($sformatf("rnd%0d word_count", it), 32'(word_count), 32'(expWc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
